// File: rtl/conv_pkg.sv
// Shared definitions for the convolution frame controller: state encoding
// and the frame geometry derived from image and filter sizes.
package conv_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_FILL   = 3'd2;
  localparam logic [2:0] ST_STREAM = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Output columns of a valid (no padding) convolution.
  function automatic int calc_ow(input int width, input int fsize);
    return width - fsize + 1;
  endfunction

  // Output rows of a valid (no padding) convolution.
  function automatic int calc_oh(input int height, input int fsize);
    return height - fsize + 1;
  endfunction

  // Pixels in one frame.
  function automatic int calc_npix(input int width, input int height);
    return width * height;
  endfunction

  // Pixels needed to prime the window buffer before the first window.
  function automatic int calc_nfill(input int width, input int fsize);
    return width * (fsize - 1);
  endfunction

endpackage

// File: rtl/conv_win_counter.sv
// Window coordinate counter: tags each accepted window with its output
// row/column and flags the final one; extra windows are dropped.
module conv_win_counter #(
  parameter int OW = 24,
  parameter int OH = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       win_valid,
  output logic       out_valid,
  output logic [7:0] out_row,
  output logic [7:0] out_col,
  output logic       out_last,
  output logic       all_done
);

  logic [7:0] row_q;
  logic [7:0] col_q;
  logic       done_q;
  logic       at_last_col;
  logic       at_last_row;

  assign at_last_col = (col_q == 8'(OW - 1));
  assign at_last_row = (row_q == 8'(OH - 1));
  assign out_valid   = win_valid & en & ~done_q;
  assign out_last    = out_valid & at_last_col & at_last_row;
  assign out_row     = row_q;
  assign out_col     = col_q;
  assign all_done    = done_q;

  // Advance the raster coordinate on every accepted window; hold at the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= 8'd0;
      col_q  <= 8'd0;
      done_q <= 1'b0;
    end else if (clr) begin
      row_q  <= 8'd0;
      col_q  <= 8'd0;
      done_q <= 1'b0;
    end else if (out_valid) begin
      if (out_last) begin
        done_q <= 1'b1;
      end else if (at_last_col) begin
        col_q <= 8'd0;
        row_q <= row_q + 8'd1;
      end else begin
        col_q <= col_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Convolution frame controller: sequences one image frame from pixel memory
// into the window buffer and forwards tagged window strobes to the MAC stage.
//
// Handshake: a memory read issues in a cycle where mem_rd_en and mem_gnt are
// both high; its data is on mem_rd_data exactly one cycle later, and that same
// cycle the pixel appears on buf_data with buf_in_val high. Window strobes are
// combinational: out_valid follows win_valid in the same cycle while busy.
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int WIDTH       = 28,
  parameter int HEIGHT      = 28,
  parameter int DATA_BITS   = 8,
  parameter int FILTER_SIZE = 5,
  parameter int ADDR_BITS   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 mem_rd_en,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic                 mem_gnt,
  input  logic [DATA_BITS-1:0] mem_rd_data,
  output logic                 buf_rst_n,
  output logic                 buf_in_val,
  output logic [DATA_BITS-1:0] buf_data,
  input  logic                 win_valid,
  output logic                 out_valid,
  output logic [7:0]           out_row,
  output logic [7:0]           out_col,
  output logic                 out_last,
  output logic [2:0]           state_dbg
);

  localparam int OW         = calc_ow(WIDTH, FILTER_SIZE);
  localparam int OH         = calc_oh(HEIGHT, FILTER_SIZE);
  localparam int NPIX       = calc_npix(WIDTH, HEIGHT);
  localparam int NFILL      = calc_nfill(WIDTH, FILTER_SIZE);
  localparam int WD_CYCLES  = 2 * WIDTH;
  localparam int WD_BITS    = $clog2(WD_CYCLES + 1);
  localparam logic [ADDR_BITS-1:0] NFILL_LAST = ADDR_BITS'(NFILL - 1);
  localparam logic [ADDR_BITS-1:0] NPIX_LAST  = ADDR_BITS'(NPIX - 1);
  localparam logic [WD_BITS-1:0]   WD_LAST    = WD_BITS'(WD_CYCLES - 1);

  logic [2:0]           state_q;
  logic [2:0]           state_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic [WD_BITS-1:0]   wd_q;
  logic                 err_q;
  logic                 val_q;
  logic                 zero_q;
  logic                 abort_q;
  logic                 aborting;
  logic                 in_fill;
  logic                 in_stream;
  logic                 slot_adv;
  logic                 win_done;
  logic                 win_clr;
  logic                 wd_expire;

  assign in_fill   = (state_q == ST_FILL);
  assign in_stream = (state_q == ST_STREAM);
  assign aborting  = abort & (state_q != ST_IDLE);
  // A slot moves the address and produces a buffer pixel: granted FILL reads,
  // and every STREAM cycle (an ungranted one becomes a zero pixel).
  assign slot_adv  = (in_fill & mem_gnt) | in_stream;
  assign wd_expire = (state_q == ST_DRAIN) & (wd_q == WD_LAST);
  assign win_clr   = aborting | (state_q == ST_CLEAR);

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign mem_rd_en  = in_fill | in_stream;
  assign mem_addr   = addr_q;
  assign buf_rst_n  = ~(rst | (state_q == ST_CLEAR) | abort_q);
  assign buf_in_val = val_q;
  assign buf_data   = (val_q & ~zero_q) ? mem_rd_data : '0;
  assign state_dbg  = state_q;

  // Next-state decode; abort overrides every busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start && !abort) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_FILL;
      ST_FILL:   if (mem_gnt && addr_q == NFILL_LAST) state_d = ST_STREAM;
      ST_STREAM: if (addr_q == NPIX_LAST) state_d = ST_DRAIN;
      ST_DRAIN:  if (win_done || wd_expire) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (aborting) state_d = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Raster address and drain watchdog; both restart outside an active frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      wd_q   <= '0;
    end else if (aborting || state_q == ST_IDLE || state_q == ST_CLEAR) begin
      addr_q <= '0;
      wd_q   <= '0;
    end else begin
      if (slot_adv && addr_q != NPIX_LAST) addr_q <= addr_q + ADDR_BITS'(1);
      if (state_q == ST_DRAIN) wd_q <= wd_q + WD_BITS'(1);
      else                     wd_q <= '0;
    end
  end

  // Sticky error: cleared by an accepted start, set by a STREAM underrun or a
  // drain timeout; an abort leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state_q == ST_IDLE && start && !abort) || state_q == ST_CLEAR) begin
      err_q <= 1'b0;
    end else if (!aborting) begin
      if (in_stream && !mem_gnt)   err_q <= 1'b1;
      else if (wd_expire && !win_done) err_q <= 1'b1;
    end
  end

  // One-cycle pipeline that lines buf_in_val up with the returning read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q   <= 1'b0;
      zero_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      val_q   <= slot_adv & ~aborting;
      zero_q  <= in_stream & ~mem_gnt & ~aborting;
      abort_q <= aborting;
    end
  end

  conv_win_counter #(
    .OW (OW),
    .OH (OH)
  ) u_win_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (win_clr),
    .en        (busy),
    .win_valid (win_valid),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .all_done  (win_done)
  );

endmodule

// File: doc/conv_frame_ctrl.md
CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

Interface
REQ-001 Parameters (name, default, meaning): WIDTH 28, image columns; HEIGHT 28, image rows; DATA_BITS 8, pixel width; FILTER_SIZE 5, window side; ADDR_BITS 10, pixel memory address width.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle frame start request; ignored unless IDLE.
REQ-005 abort  in  1  cancel the current frame; sampled in every state.
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 done  out  1  one-cycle pulse when a frame completes normally.
REQ-008 err  out  1  sticky stream-underrun flag; cleared by start or rst.
REQ-009 mem_rd_en  out  1  pixel memory read strobe.
REQ-010 mem_addr  out  ADDR_BITS  raster pixel address, row*WIDTH+col.
REQ-011 mem_gnt  in  1  memory grant; a read issues only when mem_rd_en and mem_gnt are both high.
REQ-012 mem_rd_data  in  DATA_BITS  read data, valid exactly one cycle after an issued read.
REQ-013 buf_rst_n  out  1  active-low clear to the window buffer.
REQ-014 buf_in_val / buf_data  out  1 / DATA_BITS  pixel stream to the window buffer.
REQ-015 win_valid  in  1  window-valid from the window buffer.
REQ-016 out_valid / out_row / out_col / out_last  out  1 / 8 / 8 / 1  tagged window strobe to the MAC stage.

Function
REQ-017 OW = WIDTH-FILTER_SIZE+1; OH = HEIGHT-FILTER_SIZE+1; NPIX = WIDTH*HEIGHT; NFILL = WIDTH*(FILTER_SIZE-1).
REQ-018 FSM states are IDLE, CLEAR, FILL, STREAM, DRAIN, DONE.
REQ-019 IDLE to CLEAR on start; CLEAR lasts 1 cycle with buf_rst_n=0 and clears err and all counters.
REQ-020 FILL asserts mem_rd_en and advances the address only on an issued read; it leaves FILL after NFILL reads have issued.
REQ-021 FILL tolerates mem_gnt=0 stalls; buf_in_val is held low for the stalled slot.
REQ-022 STREAM issues the remaining NPIX-NFILL reads, one per cycle; the buffer cannot stall in this phase.
REQ-023 mem_gnt=0 in STREAM sets err, sends a zero pixel with buf_in_val=1, and advances the address anyway.
REQ-024 buf_in_val and buf_data are registered copies of the issued read and mem_rd_data: one-cycle latency and no bubbles except FILL stalls.
REQ-025 DRAIN drives buf_in_val=0, buf_data=0 and waits until OW*OH windows have been counted.
REQ-026 DRAIN has a watchdog of 2*WIDTH cycles; on expiry it sets err and proceeds to DONE.
REQ-027 DONE pulses done for 1 cycle, then the FSM returns to IDLE.
REQ-028 Window counting: each win_valid cycle while busy produces out_valid on the same cycle, tagged with out_row and out_col.
REQ-029 out_col increments per window and wraps at OW-1 to 0, incrementing out_row; out_last=1 when out_row=OH-1 and out_col=OW-1.
REQ-030 win_valid after OW*OH windows, or while IDLE, is ignored: out_valid stays 0.
REQ-031 abort in any non-IDLE state goes to IDLE next cycle with buf_rst_n=0 for that cycle; no done, err unchanged.
REQ-032 start and abort high on the same cycle in IDLE: abort wins and the FSM stays IDLE.
REQ-033 The address counter never exceeds NPIX-1; mem_rd_en=0 outside FILL and STREAM.

Reset
REQ-034 On rst: state IDLE, all counters 0, busy=0, done=0, err=0, mem_rd_en=0, mem_addr=0, buf_in_val=0, buf_data=0, out_valid=0, out_last=0, out_row=0, out_col=0.
REQ-035 On rst: buf_rst_n=0 while rst is high, then 1.
REQ-036 rst mid-frame discards all progress; no done pulse is produced.

Structure
REQ-037 The state encoding and the OW, OH, NPIX and NFILL derivations live in shared package conv_pkg.
REQ-038 The window coordinate counter (REQ-029/030) is sub-module conv_win_counter; the FSM and address generator stay top-level.

Verification
REQ-039 Default parameters, mem_gnt=1, start pulse -> 112 FILL reads, 672 STREAM reads, 576 out_valid, out_last on (23,23), done once, err=0.
REQ-040 mem_gnt low for 10 random cycles during FILL -> same 576 windows, err=0, frame 10 cycles longer.
REQ-041 mem_gnt low for 1 cycle in STREAM -> err=1, a zero pixel is sent, frame still completes with done.
REQ-042 abort at pixel 300 -> IDLE next cycle, buf_rst_n low 1 cycle, no done; a following start runs a clean frame.
REQ-043 win_valid is never returned -> watchdog expires 56 cycles into DRAIN, err=1, done pulses.
REQ-044 rst asserted mid-STREAM -> all outputs at reset values immediately; start while busy has no effect.
